// File: rtl/delay_pkg.sv
// delay_pkg: shared FSM state type and tap-index width helper for the delay line
package delay_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} delay_state_t;
  function automatic int tap_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// xilinx_true_dual_port_read_first_2_clock_ram: BRAM with a write port A and a read port B
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int    RAM_WIDTH       = 32,
  parameter int    ADDR_WIDTH      = 16,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic                  clka,
  input  logic                  clkb,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [RAM_WIDTH-1:0]  dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [RAM_WIDTH-1:0]  doutb
);
  logic [RAM_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [RAM_WIDTH-1:0] ram_b;
  always_ff @(posedge clka)
    if (ena && wea) mem[addra] <= dina;
  always_ff @(posedge clkb)
    if (enb) ram_b <= mem[addrb];
  if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_hp
    always_ff @(posedge clkb) doutb <= ram_b;
  end else begin : g_ll
    assign doutb = ram_b;
  end
endmodule

// File: rtl/multi_tap_delay_line.sv
// multi_tap_delay_line: circular-buffer delay line with NUM_TAPS taps read through one BRAM port
module multi_tap_delay_line
  import delay_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_valid,
  input  logic [DATA_WIDTH-1:0]          in_sample,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0] delay_samples,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] out_samples,
  output logic [NUM_TAPS-1:0]            out_tap_valid,
  output logic                           out_sample_valid,
  output logic                           busy,
  output logic                           overrun
);
  localparam int TAP_W = tap_w(NUM_TAPS);
  delay_state_t state, state_nx;
  logic [TAP_W-1:0] tap_cnt, rd_idx;
  logic rd_valid, accept, last_tap;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_snap, rd_addr;
  logic [ADDR_WIDTH:0] fill_count;
  logic [NUM_TAPS*ADDR_WIDTH-1:0] delay_snap;
  logic [ADDR_WIDTH-1:0] d_arr [NUM_TAPS];
  logic [DATA_WIDTH-1:0] stage [NUM_TAPS];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [NUM_TAPS*DATA_WIDTH-1:0] out_nx;
  logic [NUM_TAPS-1:0] valid_nx;
  assign accept = state == IDLE && sample_valid;
  assign busy = state != IDLE;
  assign last_tap = tap_cnt == TAP_W'(NUM_TAPS - 1);
  assign rd_addr = wr_snap - d_arr[tap_cnt];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_valid) state_nx = READ;
      READ:    if (last_tap) state_nx = DRAIN;
      DRAIN:   state_nx = OUT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      d_arr[k] = delay_snap[k*ADDR_WIDTH +: ADDR_WIDTH];
      valid_nx[k] = fill_count >= {1'b0, d_arr[k]} + 1'b1;
      out_nx[k*DATA_WIDTH +: DATA_WIDTH] = valid_nx[k] ? (rd_valid && rd_idx == TAP_W'(k) ? rd_data : stage[k]) : '0;
    end
  end
  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RAM_PERFORMANCE("LOW_LATENCY")
  ) u_ram (
    .clka(clk), .clkb(clk), .ena(1'b1), .wea(accept), .addra(wr_ptr), .dina(in_sample),
    .enb(state == READ), .addrb(rd_addr), .doutb(rd_data)
  );
  always_ff @(posedge clk)
    if (rd_valid) stage[rd_idx] <= rd_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tap_cnt <= '0;
      rd_idx <= '0;
      rd_valid <= 1'b0;
      wr_ptr <= '0;
      wr_snap <= '0;
      delay_snap <= '0;
      fill_count <= '0;
      out_samples <= '0;
      out_tap_valid <= '0;
      out_sample_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      tap_cnt <= state == READ ? tap_cnt + 1'b1 : '0;
      rd_idx <= tap_cnt;
      rd_valid <= state == READ;
      out_sample_valid <= state == DRAIN;
      if (sample_valid && busy) overrun <= 1'b1;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        wr_snap <= wr_ptr;
        delay_snap <= delay_samples;
        fill_count <= fill_count + {{ADDR_WIDTH{1'b0}}, ~fill_count[ADDR_WIDTH]};
      end
      if (state == DRAIN) begin
        out_samples <= out_nx;
        out_tap_valid <= valid_nx;
      end
    end
  end
endmodule

// File: tb/tb_multi_tap_delay_line.sv
// tb_multi_tap_delay_line: scoreboard-driven directed bench for multi_tap_delay_line
module tb_multi_tap_delay_line;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_valid = 1'b0;
  logic [15:0] in_sample = '0;
  logic [11:0] delay_samples = '0;
  logic [47:0] out_samples;
  logic [2:0] out_tap_valid;
  logic out_sample_valid, busy, overrun;
  typedef struct {
    logic [47:0] data;
    logic [2:0]  valid;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [15:0] hist[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  multi_tap_delay_line #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NUM_TAPS(3)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .in_sample(in_sample),
    .delay_samples(delay_samples), .out_samples(out_samples), .out_tap_valid(out_tap_valid),
    .out_sample_valid(out_sample_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [15:0] s, input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2, input bit expect_out);
    int dl[3];
    exp_t x;
    int n;
    dl = '{int'(d0), int'(d1), int'(d2)};
    @(negedge clk);
    sample_valid = 1'b1;
    in_sample = s;
    delay_samples = {d2, d1, d0};
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    hist.push_back(s);
    n = hist.size();
    x.data = '0;
    x.valid = '0;
    for (int k = 0; k < 3; k++)
      if (n >= dl[k] + 1) begin
        x.valid[k] = 1'b1;
        x.data[k*16 +: 16] = hist[n-1-dl[k]];
      end
    x.due = cyc + 4;
    if (expect_out) sb.push_back(x);
  endtask
  always @(negedge clk)
    if (!reset && out_sample_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 64'(out_sample_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("out_samples", 64'(out_samples), 64'(e.data));
        chk("out_tap_valid", 64'(out_tap_valid), 64'(e.valid));
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_samples", 64'(out_samples), 64'd0);
    chk("rst_tap_valid", 64'(out_tap_valid), 64'd0);
    chk("rst_valid", 64'(out_sample_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    send(16'd1, 4'd0, 4'd1, 4'd5, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("busy_high", 64'(busy), 64'd1);
    end
    @(negedge clk);
    chk("busy_low", 64'(busy), 64'd0);
    for (int i = 2; i <= 6; i++) begin
      send(16'(i), 4'd0, 4'd1, 4'd5, 1'b1);
      repeat (7) @(negedge clk);
    end
    chk("ramp6_out", 64'(out_samples), 64'h0001_0005_0006);
    chk("ramp6_valid", 64'(out_tap_valid), 64'b111);
    for (int i = 0; i < 40; i++) begin
      send(16'(16'h100 + i), 4'd15, 4'd0, 4'd8, 1'b1);
      repeat (5) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    send(16'h0aaa, 4'd2, 4'd3, 4'd7, 1'b1);
    @(negedge clk);
    @(negedge clk);
    sample_valid = 1'b1;
    in_sample = 16'hdead;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(negedge clk);
    chk("overrun_set", 64'(overrun), 64'd1);
    repeat (6) @(negedge clk);
    send(16'h0bbb, 4'd0, 4'd1, 4'd2, 1'b1);
    repeat (7) @(negedge clk);
    chk("overrun_sticky", 64'(overrun), 64'd1);
    send(16'h0ccc, 4'd1, 4'd2, 4'd3, 1'b1);
    @(negedge clk);
    delay_samples = {4'd0, 4'd0, 4'd0};
    repeat (7) @(negedge clk);
    send(16'h0ddd, 4'd0, 4'd0, 4'd0, 1'b1);
    repeat (7) @(negedge clk);
    send(16'h0eee, 4'd0, 4'd1, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    hist.delete();
    repeat (8) @(negedge clk);
    chk("abort_out_samples", 64'(out_samples), 64'd0);
    chk("abort_tap_valid", 64'(out_tap_valid), 64'd0);
    chk("abort_overrun", 64'(overrun), 64'd0);
    send(16'h0777, 4'd0, 4'd2, 4'd2, 1'b1);
    repeat (7) @(negedge clk);
    chk("post_reset_valid", 64'(out_tap_valid), 64'b001);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
